aq_sensor_bank: RTL
===================

// Module: aq_sensor_bank
// PURPOSE
//   Parametrised aquarium sensor register bank with display sequencer, the successor to the fixed 4x8-bit tank registers.
//   Holds NCH sensor channels: cleanliness, temperature, food storage, saltiness, etc.
//   Range-checks each channel against per-channel thresholds and raises sticky alarms.
//   Drives one display bus with a 4-state FSM: IDLE, SCAN (auto-cycle channels), HOLD (fixed channel) and ERROR (all-ones).
// PARAMETERS
//   NCH    4  number of sensor channels (2..16)
//   WIDTH  8  bits per channel value and threshold
//   DWELL  4  cycles each channel is shown in SCAN (>=1)
//   CW     localparam = $clog2(NCH); channel index width
// PORTS
//   CLK          in   1          clock, all state updates on posedge
//   reset        in   1          asynchronous, active-low; clears all state
//   wr_en        in   NCH        per-channel load strobe
//   wr_data      in   NCH*WIDTH  per-channel load value; channel i is at [i*WIDTH +: WIDTH]
//   thr_lo       in   NCH*WIDTH  per-channel inclusive lower bound
//   thr_hi       in   NCH*WIDTH  per-channel inclusive upper bound
//   mode         in   2          00 IDLE, 01 SCAN, 10 HOLD, 11 reserved (treated as IDLE)
//   ch_sel       in   CW         channel shown in HOLD
//   err_clr      in   1          clears all alarms
//   disp_out     out  WIDTH      displayed value
//   disp_ch      out  CW         index of the displayed channel
//   disp_onehot  out  NCH        one-hot of disp_ch; in ERROR it carries the alarm vector
//   alarm        out  NCH        sticky per-channel out-of-range flags
//   err_mode     out  1          high while the FSM is in ERROR
// BEHAVIOUR
//   Reset (reset=0, async): all outputs are 0, all channel registers are 0, all valid bits are 0, FSM=IDLE, dwell counter=0.
//   Write: when wr_en[i] is high at a posedge, reg[i] takes the wr_data slice and valid[i] is set.
//     The new value is visible internally the next cycle. Writes to different channels in the same cycle are independent.
//   Range check: oor[i] = valid[i] && (reg[i] < lo[i] || reg[i] > hi[i]), unsigned compare.
//     A channel with lo[i] > hi[i] is disabled and never flags.
//     An unwritten channel (valid=0) never flags.
//   Alarm: if oor[i] is high at a posedge, alarm[i] is set; alarm rises 2 cycles after the offending write.
//     err_clr clears every alarm. If err_clr and oor[i] are high in the same cycle, set wins.
//   FSM: next state is evaluated at each posedge.
//     ERROR whenever |alarm is high, from any state; this has priority over mode.
//     Otherwise the state follows mode. ERROR exits the cycle after alarm reaches 0.
//   IDLE: disp_out=0, disp_ch=0, disp_onehot=0.
//   SCAN: entry from any other state starts at ch 0 with the dwell counter at 0.
//     disp_ch advances after DWELL cycles and wraps from NCH-1 to 0.
//   HOLD: disp_ch=ch_sel. If ch_sel >= NCH: disp_out=0 and disp_onehot=0.
//   ERROR: disp_out={WIDTH{1'b1}}, disp_ch=lowest alarmed index, disp_onehot=alarm, err_mode=1.
//   Outputs are registered. disp_out and disp_onehot reflect state/channel with 1-cycle latency.
//     disp_out reflects the current reg[disp_ch], so a write to the displayed channel appears 2 cycles later.
// CONFIGURATION
//   AQ_ERR_AUTOCLR_EN
//     Undefined: alarms are sticky until err_clr.
//     Defined: alarm[i] also clears after oor[i] has been continuously low for DWELL cycles.
//       A per-channel counter resets whenever oor[i] is high. err_clr keeps working.
// STRUCTURE
//   Package aq_pkg: state enum (IDLE, SCAN, HOLD, ERROR), mode codes, and the helper function onehot(idx, NCH).
//   Sub-module aq_chan_reg is instantiated NCH times. Each instance holds reg, valid, range compare, alarm, and the auto-clear counter.
//   The top level holds the FSM, dwell counter, display mux and the lowest-index priority encoder.
// TESTING
//   T1 Reset
//     Drive reset=0 mid-SCAN -> every output is 0 immediately; after release with mode=00, disp_out=0.
//   T2 SCAN wrap (NCH=4, DWELL=4)
//     Write ch0..3 = 0E, 1C, 38, 70 with thresholds 00/FF, mode=01.
//     -> disp_out steps 0E, 1C, 38, 70, 0E, each held 4 cycles; disp_onehot steps 0001 -> 0010 -> 0100 -> 1000 -> 0001.
//   T3 HOLD and out-of-range select
//     mode=10, ch_sel=2 -> disp_out=38, disp_onehot=0100.
//     Instantiate NCH=3 and set ch_sel=3 -> disp_out=00, disp_onehot=000.
//   T4 Alarm and ERROR
//     ch1 has lo=10, hi=30; write ch1=40 -> alarm=0010 2 cycles later, err_mode=1, disp_out=FF, disp_ch=1.
//     Rewrite ch1=20 -> alarm stays set (macro undefined).
//     Pulse err_clr -> alarm=0; the FSM returns to mode's state the following cycle.
//   T5 Set/clear collision and disabled channel
//     err_clr in the same cycle that oor[3] is high -> alarm[3]=1.
//     Channel with lo=50, hi=20 written with 00 -> alarm stays 0.
//   T6 AQ_ERR_AUTOCLR_EN defined
//     ch1=40 then ch1=20 -> alarm[1] clears DWELL cycles after oor falls, with no err_clr.

Source files
------------

// File: rtl/aq_pkg.sv
// aq_pkg: shared FSM state type, mode codes and one-hot helper for the aquarium sensor bank
package aq_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD, ERROR} state_t;
  localparam logic [1:0] MODE_SCAN = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam int MAX_CH = 16;
  function automatic logic [MAX_CH-1:0] onehot(input int idx, input int n);
    logic [MAX_CH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_CH; i++) v[i] = (i == idx) && (i < n);
    return v;
  endfunction
endpackage

// File: rtl/aq_chan_reg.sv
// aq_chan_reg: one sensor channel - value register, valid bit, range check and sticky alarm
//   With AQ_ERR_AUTOCLR_EN defined the alarm also clears after DWELL quiet cycles.
module aq_chan_reg #(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             err_clr,
  output logic [WIDTH-1:0] val,
  output logic             alarm
);
  localparam int QW = $clog2(DWELL + 1);
`ifdef AQ_ERR_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif
  logic valid, oor, quiet;
  logic [QW-1:0] quiet_cnt;
  // lo > hi disables the channel
  assign oor = valid && (lo <= hi) && (val < lo || val > hi);
  assign quiet = AUTOCLR && !oor && quiet_cnt == QW'(DWELL - 1);
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      val <= '0;
      valid <= 1'b0;
      alarm <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      if (wr_en) begin
        val <= wr_data;
        valid <= 1'b1;
      end
      alarm <= oor || (alarm && !err_clr && !quiet);
      quiet_cnt <= oor ? '0 : (quiet_cnt == QW'(DWELL)) ? quiet_cnt : quiet_cnt + QW'(1);
    end
endmodule

// File: rtl/aq_sensor_bank.sv
// aq_sensor_bank: NCH-channel aquarium sensor bank with range alarms and display sequencer
//   Define AQ_ERR_AUTOCLR_EN to let alarms self-clear after DWELL quiet cycles.
module aq_sensor_bank import aq_pkg::*; #(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  parameter int DWELL = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [NCH-1:0]       wr_en,
  input  logic [NCH*WIDTH-1:0] wr_data,
  input  logic [NCH*WIDTH-1:0] thr_lo,
  input  logic [NCH*WIDTH-1:0] thr_hi,
  input  logic [1:0]           mode,
  input  logic [CW-1:0]        ch_sel,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     disp_out,
  output logic [CW-1:0]        disp_ch,
  output logic [NCH-1:0]       disp_onehot,
  output logic [NCH-1:0]       alarm,
  output logic                 err_mode
);
  localparam int DW = $clog2(DWELL + 1);
  state_t state, state_nx;
  logic [NCH-1:0][WIDTH-1:0] vals;
  logic [CW-1:0] scan_ch, low_ch, cur_ch;
  logic [DW-1:0] dwell;
  logic [WIDTH-1:0] out_nx;
  logic [NCH-1:0] oh_nx;
  logic ch_ok;
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    aq_chan_reg #(.WIDTH(WIDTH), .DWELL(DWELL)) u_chan (
      .CLK(CLK),
      .reset(reset),
      .wr_en(wr_en[i]),
      .wr_data(wr_data[i*WIDTH +: WIDTH]),
      .lo(thr_lo[i*WIDTH +: WIDTH]),
      .hi(thr_hi[i*WIDTH +: WIDTH]),
      .err_clr(err_clr),
      .val(vals[i]),
      .alarm(alarm[i])
    );
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (|alarm) ? ERROR : (mode == MODE_SCAN) ? SCAN : (mode == MODE_HOLD) ? HOLD : IDLE;
  // scan position restarts from channel 0 on every entry into SCAN
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      dwell <= '0;
      scan_ch <= '0;
    end else if (state != SCAN || state_nx != SCAN) begin
      dwell <= '0;
      scan_ch <= '0;
    end else if (dwell == DW'(DWELL - 1)) begin
      dwell <= '0;
      scan_ch <= (scan_ch == CW'(NCH - 1)) ? '0 : scan_ch + CW'(1);
    end else dwell <= dwell + DW'(1);
  always_comb begin
    low_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) if (alarm[k]) low_ch = CW'(k);
  end
  assign ch_ok = int'(cur_ch) < NCH;
  always_comb begin
    cur_ch = (state == SCAN) ? scan_ch : (state == HOLD) ? ch_sel : (state == ERROR) ? low_ch : '0;
    out_nx = (state == ERROR) ? '1 : (state == IDLE || !ch_ok) ? '0 : vals[cur_ch];
    oh_nx = (state == ERROR) ? alarm : (state == IDLE) ? '0 : NCH'(onehot(int'(cur_ch), NCH));
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      disp_out <= '0;
      disp_ch <= '0;
      disp_onehot <= '0;
    end else begin
      disp_out <= out_nx;
      disp_ch <= cur_ch;
      disp_onehot <= oh_nx;
    end
  assign err_mode = (state == ERROR);
endmodule
